// File: rtl/shift_seq_ctrl.sv
// Cycle-by-cycle sequencer for the 8-bit universal shift register.
// Define SHIFT_SEQ_CTRL_BACK2BACK_EN to accept a new command in the DONE state.
module shift_seq_ctrl #(
   parameter int W  = 8,
   parameter int AW = 3
) (
   input  logic          CLK,
   input  logic          CLR,
   input  logic          START,
   input  logic [2:0]    OP,
   input  logic [AW-1:0] AMT,
   input  logic [W-1:0]  DIN,
   input  logic [W-1:0]  Q_FB,
   output logic [1:0]    S,
   output logic          SDL,
   output logic          SDR,
   output logic [W-1:0]  D,
   output logic          BUSY,
   output logic          DONE
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [2:0] OP_LOAD = 3'b000;
   localparam logic [2:0] OP_SLL  = 3'b001;
   localparam logic [2:0] OP_SRL  = 3'b010;
   localparam logic [2:0] OP_SRA  = 3'b011;
   localparam logic [2:0] OP_ROL  = 3'b100;
   localparam logic [2:0] OP_ROR  = 3'b101;

   localparam logic [1:0] S_HOLD  = 2'b00;
   localparam logic [1:0] S_RIGHT = 2'b01;
   localparam logic [1:0] S_LEFT  = 2'b10;
   localparam logic [1:0] S_LOAD  = 2'b11;

`ifdef SHIFT_SEQ_CTRL_BACK2BACK_EN
   localparam bit B2B = 1'b1;
`else
   localparam bit B2B = 1'b0;
`endif

   logic [1:0]    state;
   logic [1:0]    state_n;
   logic [2:0]    op_r;
   logic [AW-1:0] cnt;
   logic [W-1:0]  din_r;

   logic          accept;
   logic          is_load;
   logic          is_shift;
   logic [1:0]    start_dest;

   // Only the end bits of Q feed back (sign fill and rotate wrap).
   logic          unused_fb;
   assign unused_fb = ^Q_FB[W-2:1];

   assign is_load  = (OP == OP_LOAD);
   assign is_shift = (OP >= OP_SLL) && (OP <= OP_ROR);

   assign accept = START &&
                   ((state == ST_IDLE) ||
                    (B2B && (state == ST_DONE)));

   always_comb begin
      start_dest = ST_DONE;
      unique case (1'b1)
         is_load:
            start_dest = ST_LOAD;
         is_shift && (AMT != '0):
            start_dest = ST_SHIFT;
         default:
            start_dest = ST_DONE;
      endcase
   end

   always_comb begin
      state_n = state;
      unique case (state)
         ST_IDLE:
            if (accept) state_n = start_dest;
         ST_LOAD:
            state_n = ST_DONE;
         ST_SHIFT:
            if (cnt == AW'(1)) state_n = ST_DONE;
         ST_DONE:
            state_n = accept ? start_dest : ST_IDLE;
         default:
            state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state <= ST_IDLE;
         op_r  <= '0;
         cnt   <= '0;
         din_r <= '0;
      end else begin
         state <= state_n;
         if (accept) begin
            op_r  <= OP;
            cnt   <= AMT;
            din_r <= DIN;
         end else if (state == ST_SHIFT) begin
            cnt <= cnt - AW'(1);
         end
      end
   end

   // Serial inputs come straight from Q so rotate/sign fill track each step.
   always_comb begin
      S   = S_HOLD;
      SDL = 1'b0;
      SDR = 1'b0;
      unique case (state)
         ST_LOAD:
            S = S_LOAD;
         ST_SHIFT: begin
            unique case (op_r)
               OP_SLL: begin
                  S = S_LEFT;
               end
               OP_SRL: begin
                  S = S_RIGHT;
               end
               OP_SRA: begin
                  S   = S_RIGHT;
                  SDR = Q_FB[W-1];
               end
               OP_ROL: begin
                  S   = S_LEFT;
                  SDL = Q_FB[W-1];
               end
               OP_ROR: begin
                  S   = S_RIGHT;
                  SDR = Q_FB[0];
               end
               default: begin
                  S = S_HOLD;
               end
            endcase
         end
         default: begin
            S = S_HOLD;
         end
      endcase
   end

   assign D    = din_r;
   assign BUSY = (state == ST_LOAD) || (state == ST_SHIFT);
   assign DONE = (state == ST_DONE);

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Sequencer for the 8-bit universal shift register (`shift_reg_8b`).
- Accepts a single op command (load, logical/arithmetic shift, rotate) with an amount of 0-7.
- Drives the register's S/SDL/SDR/D inputs cycle by cycle, using Q feedback for rotate and sign fill.
- Sits between the control unit and one `shift_reg_8b` instance; the register's CLRb is driven separately.

Parameters:
- W, 8, register width (fixed at 8; not to be changed).
- AW, 3, amount width; max amount is 2**AW-1 = 7.

Ports:
- CLK  in  1  clock; all state changes on rising edge
- CLR  in  1  asynchronous, active-high reset
- START  in  1  command strobe; sampled only when ready (see Behaviour)
- OP  in  3  000 LOAD, 001 SLL, 010 SRL, 011 SRA, 100 ROL, 101 ROR, 110/111 NOP
- AMT  in  3  shift/rotate count 0-7; ignored for LOAD/NOP
- DIN  in  8  load data for LOAD
- Q_FB  in  8  current Q of the shift register
- S  out  2  register mode: 00 hold, 01 right (Q<={SDR,Q[7:1]}), 10 left (Q<={Q[6:0],SDL}), 11 load D
- SDL  out  1  serial input entering Q[0] on a left shift
- SDR  out  1  serial input entering Q[7] on a right shift
- D  out  8  parallel data to register (latched DIN)
- BUSY  out  1  high in LOAD and SHIFT states
- DONE  out  1  one-cycle completion pulse

Behaviour:
- FSM states: IDLE, LOAD, SHIFT, DONE. Registers: state, op_r[2:0], cnt[2:0], din_r[7:0].
- CLR (async): state=IDLE, cnt=0, op_r=0, din_r=0. Outputs immediately S=00, SDL=0, SDR=0, D=0, BUSY=0, DONE=0.
- Reset mid-operation: the register keeps its partial result; the controller never clears the register.
- IDLE: START=1 at edge t latches OP, AMT, DIN, then:
  - LOAD -> LOAD state.
  - Shift/rotate with AMT!=0 -> SHIFT, cnt=AMT.
  - Shift/rotate with AMT=0 -> DONE.
  - NOP -> DONE.
- LOAD state (exactly one cycle): S=11, D=din_r. Next state DONE. The register loads at edge t+1.
- SHIFT state: lasts cnt cycles. cnt decrements each edge; the edge where cnt==1 goes to DONE. Register updates at edges t+1..t+AMT. Per-cycle outputs, combinational from op_r and Q_FB:
  - SLL: S=10, SDL=0.
  - SRL: S=01, SDR=0.
  - SRA: S=01, SDR=Q_FB[7].
  - ROL: S=10, SDL=Q_FB[7].
  - ROR: S=01, SDR=Q_FB[0].
- DONE state: one cycle, DONE=1, BUSY=0, S=00, then IDLE.
- Latency: LOAD has DONE in cycle t+2 (between edges t+1 and t+2). A shift of n has DONE in cycle t+n+1. AMT=0 or NOP has DONE in cycle t+1 with S never leaving 00.
- S=00 and SDL=SDR=0 in IDLE and DONE. The unused serial input is 0. D=din_r at all times.
- START in LOAD/SHIFT is ignored: no relatch, no queueing. START in DONE follows the Optional Feature.
- Output timing: S/SDL/SDR are combinational from registered state plus Q_FB. Q_FB must be a registered value to avoid loops.

Optional Feature:
- Macro: SHIFT_SEQ_CTRL_BACK2BACK_EN.
- Defined: START in the DONE state is accepted exactly as in IDLE (same latch and next-state rules). This gives zero idle cycles between commands. DONE still pulses for the finishing op.
- Undefined: START in DONE is ignored. The next command must be presented while in IDLE.

Test Plan:
- LOAD DIN=0x2E (with `shift_reg_8b` attached, CLRb=1) -> S=11 for one cycle; Q=0x2E after edge t+1; DONE=1 for exactly one cycle.
- Q=0x2E, SLL AMT=3 -> S=10 for 3 cycles, BUSY=1 for 3 cycles, Q=0x70, then DONE pulse. Follow with ROR AMT=3 on reloaded 0x2E -> Q=0xC5.
- Q=0x96, SRA AMT=2 -> SDR=1 each cycle, Q=0xE5. Q=0x81, ROL AMT=1 -> Q=0x03. Q=0x96, SRL AMT=7 -> Q=0x01.
- SLL AMT=0 and OP=110 -> DONE in the cycle after START; S stays 00; Q unchanged.
- START pulsed (LOAD 0xFF) during a 5-cycle SRL -> ignored; exactly 5 shifts, one DONE, Q not 0xFF.
- CLR asserted mid-SHIFT (2 of 5 shifts done, Q=0x2E SLL) -> S=00 and BUSY=0 immediately without a clock edge; Q holds 0xB8; no DONE.
- With SHIFT_SEQ_CTRL_BACK2BACK_EN, START held in DONE -> next op starts with no IDLE cycle; without the macro -> one IDLE cycle is required.
